// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Hazard and forwarding controller beside decode. Tracks the
//            destination registers of in-flight instructions over FWD_DEPTH
//            post-decode stages. Picks the youngest forwarding source for
//            each decode operand, stalls decode on load-use hazards, and
//            squashes fetch/decode on a taken branch.
// Ports    : clk_i, reset_i            clock, synchronous active-high reset
//            id_*_i                    decode instruction fields
//            ex_branch_taken_i         taken branch resolved in execute
//            fwd_sel_rs1_o/_rs2_o      0 = register file, k = stage k result
//            stall_o, flush_o, issue_o fetch/decode pipeline control
//            stall_cycles_o            saturating count of stall cycles
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_LAT   = 1,
  parameter int FSEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_use_rs1_i,
  input  logic                  id_use_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_we_i,
  input  logic                  id_is_load_i,
  input  logic                  ex_branch_taken_i,
  output logic [FSEL_W-1:0]     fwd_sel_rs1_o,
  output logic [FSEL_W-1:0]     fwd_sel_rs2_o,
  output logic                  stall_o,
  output logic                  flush_o,
  output logic                  issue_o,
  output logic [15:0]           stall_cycles_o
);

  // Scoreboard entries 1..FWD_DEPTH; entry 1 is the execute stage.
  logic [FWD_DEPTH:1]    valid_q;
  logic [FWD_DEPTH:1]    we_q;
  logic [FWD_DEPTH:1]    load_q;
  logic [REG_ADDR_W-1:0] rd_q [1:FWD_DEPTH];

  logic [15:0]           stall_cycles_q;
  logic [15:0]           stall_cycles_d;

  logic [FSEL_W-1:0]     sel_rs1;
  logic [FSEL_W-1:0]     sel_rs2;
  logic                  load_hz_rs1;
  logic                  load_hz_rs2;
  logic                  hazard;
  logic                  flush;
  logic                  stall;
  logic                  issue;

  // Youngest match search. Scanning from the oldest stage towards stage 1
  // lets each younger match overwrite the older one, so the final value is
  // the smallest matching k. The load-hazard flag rides along with the
  // selected stage so only the youngest producer decides the stall.
  always_comb begin
    sel_rs1     = '0;
    sel_rs2     = '0;
    load_hz_rs1 = 1'b0;
    load_hz_rs2 = 1'b0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (valid_q[k] && we_q[k] && id_use_rs1_i &&
          (id_rs1_i != '0) && (rd_q[k] == id_rs1_i)) begin
        sel_rs1     = FSEL_W'(k);
        load_hz_rs1 = load_q[k] && (k <= LOAD_LAT);
      end
      if (valid_q[k] && we_q[k] && id_use_rs2_i &&
          (id_rs2_i != '0) && (rd_q[k] == id_rs2_i)) begin
        sel_rs2     = FSEL_W'(k);
        load_hz_rs2 = load_q[k] && (k <= LOAD_LAT);
      end
    end
  end

  // Flush wins over stall; everything is quiet while reset is held so a
  // stale scoreboard can never leak a stall or forward select.
  assign hazard = id_valid_i && (load_hz_rs1 || load_hz_rs2);
  assign flush  = ex_branch_taken_i && !reset_i;
  assign stall  = hazard && !ex_branch_taken_i && !reset_i;
  assign issue  = id_valid_i && !stall && !flush && !reset_i;

  assign fwd_sel_rs1_o = reset_i ? '0 : sel_rs1;
  assign fwd_sel_rs2_o = reset_i ? '0 : sel_rs2;
  assign stall_o       = stall;
  assign flush_o       = flush;
  assign issue_o       = issue;

  // Stage 1 captures the decode instruction when it issues, a bubble
  // otherwise. x0 writes are dropped here so they can never match.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q[1] <= 1'b0;
      we_q[1]    <= 1'b0;
      load_q[1]  <= 1'b0;
      rd_q[1]    <= '0;
    end else begin
      valid_q[1] <= issue;
      we_q[1]    <= id_we_i && (id_rd_i != '0);
      load_q[1]  <= id_is_load_i;
      rd_q[1]    <= id_rd_i;
    end
  end

  // Later stages always advance, even during a stall.
  generate
    for (genvar k = 2; k <= FWD_DEPTH; k++) begin : g_stage
      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          valid_q[k] <= 1'b0;
          we_q[k]    <= 1'b0;
          load_q[k]  <= 1'b0;
          rd_q[k]    <= '0;
        end else begin
          valid_q[k] <= valid_q[k-1];
          we_q[k]    <= we_q[k-1];
          load_q[k]  <= load_q[k-1];
          rd_q[k]    <= rd_q[k-1];
        end
      end
    end
  endgenerate

  // Saturating stall counter.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles_o = stall_cycles_q;

endmodule
`default_nettype wire
